// File: rtl/regfile_alu_pkg.sv
// Shared types and default sizes for the register-file ALU sequencer.
package regfile_alu_pkg;

    localparam int DEF_N = 5;
    localparam int DEF_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_LDI = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_t;

endpackage

// File: rtl/regfile_alu_core.sv
// Combinational ALU: computes result, zero and carry/borrow for one opcode.
module regfile_alu_core
    import regfile_alu_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  opcode_t        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   imm,
    output logic [W-1:0]   y,
    output logic           zero,
    output logic           carry
);

    // Only the low log2(W) bits of b select the shift distance.
    localparam int SW = (W > 1) ? $clog2(W) : 1;

    logic [W:0]    sum;
    logic [W:0]    diff;
    logic [SW-1:0] shamt;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SW-1:0];

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                y     = sum[W-1:0];
                carry = sum[W];
            end
            OP_SUB: begin
                y     = diff[W-1:0];
                carry = diff[W];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_LDI:  y = imm;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/regfile_alu_seq.sv
// Four-state sequencer: accept instruction, read operands, execute, write back.
module regfile_alu_seq
    import regfile_alu_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] rs1_sel,
    input  logic [N-1:0] rs2_sel,
    input  logic [N-1:0] rd_sel,
    input  logic [W-1:0] imm,
    output logic [N-1:0] addr_rs1,
    output logic [N-1:0] addr_rs2,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    output logic [N-1:0] addr_rd,
    output logic [W-1:0] data_in,
    output logic         we,
    output logic         done,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         carry
);

    state_t         state;
    state_t         next_state;
    opcode_t        op_q;
    logic [N-1:0]   rs1_sel_q;
    logic [N-1:0]   rs2_sel_q;
    logic [N-1:0]   rd_sel_q;
    logic [W-1:0]   imm_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   alu_y;
    logic           alu_zero;
    logic           alu_carry;
    logic           accept;

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= OP_ADD;
            rs1_sel_q <= '0;
            rs2_sel_q <= '0;
            rd_sel_q  <= '0;
            imm_q     <= '0;
        end else if (accept) begin
            op_q      <= opcode_t'(op);
            rs1_sel_q <= rs1_sel;
            rs2_sel_q <= rs2_sel;
            rd_sel_q  <= rd_sel;
            imm_q     <= imm;
        end
    end

    // Register-file read data is combinational, so it is sampled at the end of READ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (state == ST_READ) begin
            a_q <= rs1;
            b_q <= rs2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
        end else if (state == ST_EXEC) begin
            result <= alu_y;
            zero   <= alu_zero;
            carry  <= alu_carry;
        end
    end

    regfile_alu_core #(
        .W(W)
    ) u_core (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .imm   (imm_q),
        .y     (alu_y),
        .zero  (alu_zero),
        .carry (alu_carry)
    );

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        addr_rs1    = '0;
        addr_rs2    = '0;
        addr_rd     = '0;
        data_in     = '0;
        we          = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    next_state = ST_READ;
                end
            end
            ST_READ: begin
                addr_rs1   = rs1_sel_q;
                addr_rs2   = rs2_sel_q;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                next_state = ST_WB;
            end
            ST_WB: begin
                // Register 0 is hardwired, so its write is dropped but completion still signals.
                addr_rd    = rd_sel_q;
                data_in    = result;
                we         = (rd_sel_q != '0);
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Directed bench for regfile_alu_seq with a behavioural 32x8 register file.
module tb_regfile_alu_seq;
    import regfile_alu_pkg::*;

    localparam int N = 5;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         instr_valid;
    logic         instr_ready;
    logic [2:0]   op;
    logic [N-1:0] rs1_sel;
    logic [N-1:0] rs2_sel;
    logic [N-1:0] rd_sel;
    logic [W-1:0] imm;
    logic [N-1:0] addr_rs1;
    logic [N-1:0] addr_rs2;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [N-1:0] addr_rd;
    logic [W-1:0] data_in;
    logic         we;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;

    logic [W-1:0] rf [0:(1<<N)-1];
    int           tests_run;
    int           tests_failed;
    logic         watch_abort;
    int           abort_we;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] rd;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [W-1:0] imm;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         w;
    } vec_t;

    vec_t vecs[$];

    regfile_alu_seq #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .rs1_sel     (rs1_sel),
        .rs2_sel     (rs2_sel),
        .rd_sel      (rd_sel),
        .imm         (imm),
        .addr_rs1    (addr_rs1),
        .addr_rs2    (addr_rs2),
        .rs1         (rs1),
        .rs2         (rs2),
        .addr_rd     (addr_rd),
        .data_in     (data_in),
        .we          (we),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .carry       (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file writes whatever the DUT enables, so a stray r0 write is visible.
    assign rs1 = rf[addr_rs1];
    assign rs2 = rf[addr_rs2];
    always @(posedge clk) begin
        if (we) rf[addr_rd] <= data_in;
        if (watch_abort && we) abort_we <= abort_we + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Called in READ (cycle 1); returns in the WB cycle, or after the budget expires.
    task automatic waitDone(input string tag, output logic got);
        got = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (done) begin
                got = 1'b1;
                checkOutput({tag, " latency"}, c, 3);
                break;
            end
            checkOutput({tag, " ready busy"}, instr_ready, 0);
            checkOutput({tag, " we idle"}, we, 0);
            @(posedge clk); #1;
        end
        checkOutput({tag, " done seen"}, got, 1);
        if (got) checkOutput({tag, " ready in wb"}, instr_ready, 0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag, output logic got);
        op          = v.op;
        rd_sel      = v.rd;
        rs1_sel     = v.ra;
        rs2_sel     = v.rb;
        imm         = v.imm;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (v.op != OP_LDI) begin
            checkOutput({tag, " addr_rs1"}, addr_rs1, v.ra);
            checkOutput({tag, " addr_rs2"}, addr_rs2, v.rb);
        end
        waitDone(tag, got);
    endtask

    function automatic vec_t mk(logic [2:0] o, int rd, int ra, int rb, int im,
                                int res, logic z, logic c, logic w);
        vec_t v;
        v.op = o; v.rd = N'(rd); v.ra = N'(ra); v.rb = N'(rb); v.imm = W'(im);
        v.res = W'(res); v.z = z; v.c = c; v.w = w;
        return v;
    endfunction

    initial begin
        logic got;
        string tag;
        vec_t  v;

        tests_run    = 0;
        tests_failed = 0;
        watch_abort  = 1'b0;
        abort_we     = 0;
        for (int i = 0; i < (1<<N); i++) rf[i] = '0;
        instr_valid = 1'b0;
        op = 3'b000; rs1_sel = '0; rs2_sel = '0; rd_sel = '0; imm = '0;

        vecs.push_back(mk(OP_LDI, 1, 0, 0, 200, 200, 0, 0, 1));
        vecs.push_back(mk(OP_LDI, 2, 0, 0, 100, 100, 0, 0, 1));
        vecs.push_back(mk(OP_ADD, 3, 1, 2, 0,    44, 0, 1, 1));
        vecs.push_back(mk(OP_SUB, 4, 2, 1, 0,   156, 0, 1, 1));
        vecs.push_back(mk(OP_SUB, 5, 1, 1, 0,     0, 1, 0, 1));
        vecs.push_back(mk(OP_LDI, 0, 0, 0, 55,   55, 0, 0, 0));
        vecs.push_back(mk(OP_AND, 7, 1, 2, 0,    64, 0, 0, 1));
        vecs.push_back(mk(OP_OR,  8, 1, 2, 0,   236, 0, 0, 1));
        vecs.push_back(mk(OP_XOR, 9, 1, 2, 0,   172, 0, 0, 1));
        vecs.push_back(mk(OP_LDI, 10, 0, 0, 3,    3, 0, 0, 1));
        vecs.push_back(mk(OP_SLL, 11, 2, 10, 0,  32, 0, 0, 1));
        vecs.push_back(mk(OP_SRL, 12, 1, 10, 0,  25, 0, 0, 1));
        vecs.push_back(mk(OP_LDI, 13, 0, 0, 9,    9, 0, 0, 1));
        vecs.push_back(mk(OP_SLL, 14, 2, 13, 0, 200, 0, 0, 1));
        vecs.push_back(mk(OP_SLL, 19, 1, 10, 0,  64, 0, 0, 1));
        vecs.push_back(mk(OP_ADD, 15, 0, 5, 0,    0, 1, 0, 1));
        vecs.push_back(mk(OP_SUB, 16, 1, 2, 0,  100, 0, 0, 1));
        vecs.push_back(mk(OP_ADD, 17, 2, 2, 0,  200, 0, 0, 1));

        // Reset values
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset instr_ready", instr_ready, 1);
        checkOutput("reset we", we, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset addr_rs1", addr_rs1, 0);
        checkOutput("reset addr_rs2", addr_rs2, 0);
        checkOutput("reset addr_rd", addr_rd, 0);
        checkOutput("reset data_in", data_in, 0);
        checkOutput("reset result", result, 0);
        checkOutput("reset zero", zero, 0);
        checkOutput("reset carry", carry, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            v   = vecs[i];
            tag = $sformatf("vec%0d", i);
            applyStimulus(v, tag, got);
            if (got) begin
                checkOutput({tag, " we"}, we, v.w);
                checkOutput({tag, " addr_rd"}, addr_rd, v.rd);
                checkOutput({tag, " data_in"}, data_in, v.res);
                checkOutput({tag, " result"}, result, v.res);
                checkOutput({tag, " zero"}, zero, v.z);
                checkOutput({tag, " carry"}, carry, v.c);
            end
            @(posedge clk); #1;
            checkOutput({tag, " done pulse"}, done, 0);
            checkOutput({tag, " back to idle"}, instr_ready, 1);
        end

        checkOutput("rf r0", rf[0], 0);
        checkOutput("rf r1", rf[1], 200);
        checkOutput("rf r2", rf[2], 100);
        checkOutput("rf r3", rf[3], 44);
        checkOutput("rf r4", rf[4], 156);
        checkOutput("rf r5", rf[5], 0);
        checkOutput("rf r14", rf[14], 200);

        // Back-to-back: valid stays high, second fields presented while busy
        op = OP_LDI; rd_sel = 5'd20; imm = 8'd77; rs1_sel = '0; rs2_sel = '0;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        rd_sel = 5'd21; imm = 8'd88;
        waitDone("b2b first", got);
        checkOutput("b2b first addr_rd", addr_rd, 20);
        checkOutput("b2b first data_in", data_in, 77);
        checkOutput("b2b first we", we, 1);
        @(posedge clk); #1;
        checkOutput("b2b cycle4 ready", instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        waitDone("b2b second", got);
        checkOutput("b2b second addr_rd", addr_rd, 21);
        checkOutput("b2b second data_in", data_in, 88);
        @(posedge clk); #1;
        checkOutput("b2b rf r20", rf[20], 77);
        checkOutput("b2b rf r21", rf[21], 88);

        // Abort: reset lands in the middle of EXEC of ADD r6
        watch_abort = 1'b1;
        op = OP_ADD; rd_sel = 5'd6; rs1_sel = 5'd1; rs2_sel = 5'd2; imm = '0;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        checkOutput("abort async ready", instr_ready, 1);
        checkOutput("abort async we", we, 0);
        checkOutput("abort async result", result, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort ready after release", instr_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        watch_abort = 1'b0;
        checkOutput("abort we count", abort_we, 0);
        checkOutput("abort rf r6", rf[6], 0);

        v = mk(OP_ADD, 6, 1, 2, 0, 44, 0, 1, 1);
        applyStimulus(v, "recover", got);
        if (got) checkOutput("recover data_in", data_in, 44);
        @(posedge clk); #1;
        checkOutput("recover rf r6", rf[6], 44);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_alu_seq.md
REGFILE_ALU_SEQ -- requirements
Module: regfile_alu_seq

Interface
REQ-001 Parameter N, default 5, register-file address width (2^N registers).
REQ-002 Parameter W, default 8, data width.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 instr_valid  input  1  instruction present on op/sel/imm inputs.
REQ-006 instr_ready  output  1  block can accept an instruction.
REQ-007 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 LDI.
REQ-008 rs1_sel, rs2_sel, rd_sel  input  N each  source and destination register indices.
REQ-009 imm  input  W  immediate operand for LDI.
REQ-010 addr_rs1, addr_rs2  output  N each  register-file read addresses.
REQ-011 rs1, rs2  input  W each  register-file combinational read data.
REQ-012 addr_rd  output  N  register-file write address.
REQ-013 data_in  output  W  register-file write data.
REQ-014 we  output  1  register-file write enable.
REQ-015 done  output  1  one-cycle pulse at instruction completion.
REQ-016 result  output  W  last computed result, held until the next EXEC.
REQ-017 zero, carry  output  1 each  flags of the last result, held like result.

Function
REQ-018 FSM states IDLE, READ, EXEC, WB; transitions IDLE->READ on instr_valid && instr_ready; READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-019 instr_ready = 1 only in IDLE; the handshake latches op, rs1_sel, rs2_sel, rd_sel and imm into internal registers.
REQ-020 In READ, addr_rs1/addr_rs2 drive the latched selects; rs1/rs2 are captured into operand registers at the end of READ.
REQ-021 In EXEC, the ALU output, zero and carry are registered into result/zero/carry.
REQ-022 In WB: addr_rd = latched rd_sel; data_in = result; we = 1 unless rd_sel == 0; done = 1.
REQ-023 Latency: handshake in cycle 0; READ in cycle 1; EXEC in cycle 2; WB/done in cycle 3. Throughput is one instruction per 4 cycles.
REQ-024 ADD: the W+1-bit sum gives result = low W bits and carry = bit W.
REQ-025 SUB: result = rs1 - rs2 mod 2^W; carry = borrow (rs1 < rs2 unsigned).
REQ-026 AND/OR/XOR: bitwise; carry = 0.
REQ-027 SLL/SRL: logical shift of rs1 by rs2[$clog2(W)-1:0]; carry = 0.
REQ-028 LDI: result = imm, rs operands ignored, carry = 0.
REQ-029 zero = (result == 0) for every opcode.
REQ-030 Write to register 0 is suppressed (we stays 0); done still pulses.
REQ-031 we and done are 0 in every state except WB.
REQ-032 instr_valid outside IDLE is ignored and does not alter latched fields.

Reset
REQ-033 rst low forces IDLE immediately, independent of clk.
REQ-034 Reset values: instr_ready 1, we 0, done 0, addr_rs1/addr_rs2/addr_rd 0, data_in 0, result 0, zero 0, carry 0.
REQ-035 A reset asserted mid-instruction aborts it; no write occurs.

Structure
REQ-036 Package regfile_alu_pkg holds the opcode enum, the FSM state enum and the default N/W constants.
REQ-037 A combinational sub-module regfile_alu_core (op, a, b, imm -> y, zero, carry) implements REQ-024..029.

Verification
REQ-038 LDI rd=1 imm=200, then LDI rd=2 imm=100 -> WB cycle 3 shows we=1, addr_rd=1, data_in=200; register file reads r1=200, r2=100.
REQ-039 ADD rd=3 rs1=1 rs2=2 -> result 44, carry 1, zero 0; r3=44.
REQ-040 SUB rd=4 rs1=2 rs2=1 -> result 156, carry 1. SUB rd=5 rs1=1 rs2=1 -> result 0, zero 1, carry 0.
REQ-041 LDI rd=0 imm=55 -> done pulses, we stays 0, r0 reads 0.
REQ-042 instr_valid held high for two instructions -> instr_ready low in cycles 1-3; second handshake occurs in cycle 4; both writes land.
REQ-043 rst low during EXEC of ADD rd=6 -> we never asserted, r6 unchanged, instr_ready=1 the cycle after release.
